// File: rtl/i2c_responder.sv
// I2C target exposing a 16x8 register file: 0x01/0x02 drive cfg1/cfg2, 0x09-0x0E are
// read-only sample registers loaded as one image only while the bus is not mid-transfer.
`timescale 1ns/1ps
module i2c_responder #(
  parameter logic [6:0]  DEVICE_ADDRESS = 7'h44,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        scl,
  inout  wire         sda,
  input  logic [47:0] sample,
  input  logic        sample_valid,
  output logic [7:0]  cfg1,
  output logic [7:0]  cfg2,
  output logic        busy,
  output logic        wr_strobe
);

  typedef enum logic [3:0] {
    StIdle, StAddr, StAddrAck, StReg, StRegAck,
    StWdata, StWdataAck, StRdata, StRdataAck, StWaitStop
  } state_e;

  state_e state_q, state_d;
  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic scl_p_q, sda_p_q;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [3:0] ptr_q, ptr_d;
  logic sda_oe_q, sda_oe_d;
  logic busy_q, busy_d;
  logic rw_q, rw_d;
  logic ack_q, ack_d;
  logic wr_strobe_q, wr_strobe_d;
  logic pend_q, pend_d;
  logic [47:0] pend_data_q, pend_data_d;
  logic [7:0] regs_q [16];
  logic [7:0] regs_d [16];

  logic scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;
  logic [7:0] wbyte;
  logic [3:0] rd_ptr;
  logic quiet;

  assign scl_s     = scl_sync_q[SYNC_STAGES-1];
  assign sda_s     = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_p_q;
  assign scl_fall  = ~scl_s & scl_p_q;
  assign start_det = scl_s & scl_p_q & sda_p_q & ~sda_s;
  assign stop_det  = scl_s & scl_p_q & ~sda_p_q & sda_s;

  assign sda       = sda_oe_q ? 1'b0 : 1'bz;
  assign cfg1      = regs_q[1];
  assign cfg2      = regs_q[2];
  assign busy      = busy_q;
  assign wr_strobe = wr_strobe_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    ptr_d       = ptr_q;
    sda_oe_d    = sda_oe_q;
    busy_d      = busy_q;
    rw_d        = rw_q;
    ack_d       = ack_q;
    wr_strobe_d = 1'b0;
    pend_d      = pend_q;
    pend_data_d = pend_data_q;
    regs_d      = regs_q;
    wbyte       = {shift_q[6:0], sda_s};
    rd_ptr      = ptr_q + 4'd1;
    quiet       = (state_q == StIdle) || (state_q == StWaitStop);

    if (start_det) begin
      state_d  = StAddr;
      cnt_d    = 4'd0;
      sda_oe_d = 1'b0;
      busy_d   = 1'b1;
    end else if (stop_det) begin
      state_d  = StIdle;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else begin
      unique case (state_q)
        StAddr: begin
          if (scl_rise) begin
            shift_d = wbyte;
            cnt_d   = cnt_q + 4'd1;
          end else if (scl_fall && cnt_q == 4'd8) begin
            rw_d = shift_q[0];
            if (shift_q[7:1] == DEVICE_ADDRESS) begin
              state_d  = StAddrAck;
              sda_oe_d = 1'b1;
            end else begin
              state_d = StWaitStop;
              busy_d  = 1'b0;
            end
          end
        end
        StAddrAck: begin
          if (scl_fall) begin
            cnt_d = 4'd0;
            if (rw_q) begin
              // First data bit goes out on the same falling edge that ends the ACK.
              state_d  = StRdata;
              shift_d  = regs_q[ptr_q];
              sda_oe_d = ~regs_q[ptr_q][7];
            end else begin
              state_d  = StReg;
              sda_oe_d = 1'b0;
            end
          end
        end
        StReg: begin
          if (scl_rise) begin
            shift_d = wbyte;
            cnt_d   = cnt_q + 4'd1;
          end else if (scl_fall && cnt_q == 4'd8) begin
            ptr_d    = shift_q[3:0];
            state_d  = StRegAck;
            sda_oe_d = 1'b1;
          end
        end
        StRegAck, StWdataAck: begin
          if (scl_fall) begin
            state_d  = StWdata;
            cnt_d    = 4'd0;
            sda_oe_d = 1'b0;
          end
        end
        StWdata: begin
          if (scl_rise) begin
            shift_d = wbyte;
            cnt_d   = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              if (!(ptr_q >= 4'h9 && ptr_q <= 4'hE)) begin
                regs_d[ptr_q] = wbyte;
                wr_strobe_d   = 1'b1;
              end
              ptr_d = rd_ptr;
            end
          end else if (scl_fall && cnt_q == 4'd8) begin
            state_d  = StWdataAck;
            sda_oe_d = 1'b1;
          end
        end
        StRdata: begin
          if (scl_rise) begin
            cnt_d = cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (cnt_q == 4'd8) begin
              state_d  = StRdataAck;
              sda_oe_d = 1'b0;
            end else begin
              shift_d  = {shift_q[6:0], 1'b0};
              sda_oe_d = ~shift_q[6];
            end
          end
        end
        StRdataAck: begin
          if (scl_rise) begin
            ack_d = ~sda_s;
            cnt_d = 4'd9;
          end else if (scl_fall && cnt_q == 4'd9) begin
            if (ack_q) begin
              ptr_d    = rd_ptr;
              shift_d  = regs_q[rd_ptr];
              sda_oe_d = ~regs_q[rd_ptr][7];
              cnt_d    = 4'd0;
              state_d  = StRdata;
            end else begin
              state_d = StWaitStop;
            end
          end
        end
        StIdle, StWaitStop: ;
        default: state_d = StIdle;
      endcase
    end

    // Sample image only lands between transfers so a read never sees a mix.
    if (sample_valid) begin
      if (quiet) begin
        for (int k = 0; k < 6; k++) regs_d[4'(9 + k)] = sample[8*k +: 8];
        pend_d = 1'b0;
      end else begin
        pend_d      = 1'b1;
        pend_data_d = sample;
      end
    end else if (pend_q && quiet) begin
      for (int k = 0; k < 6; k++) regs_d[4'(9 + k)] = pend_data_q[8*k +: 8];
      pend_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      scl_sync_q  <= {SYNC_STAGES{1'b1}};
      sda_sync_q  <= {SYNC_STAGES{1'b1}};
      scl_p_q     <= 1'b1;
      sda_p_q     <= 1'b1;
      state_q     <= StIdle;
      cnt_q       <= 4'd0;
      shift_q     <= 8'h00;
      ptr_q       <= 4'd0;
      sda_oe_q    <= 1'b0;
      busy_q      <= 1'b0;
      rw_q        <= 1'b0;
      ack_q       <= 1'b0;
      wr_strobe_q <= 1'b0;
      pend_q      <= 1'b0;
      pend_data_q <= 48'h0;
      regs_q      <= '{default: 8'h00};
    end else begin
      scl_sync_q  <= {scl_sync_q[SYNC_STAGES-2:0], scl};
      sda_sync_q  <= {sda_sync_q[SYNC_STAGES-2:0], sda};
      scl_p_q     <= scl_s;
      sda_p_q     <= sda_s;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      ptr_q       <= ptr_d;
      sda_oe_q    <= sda_oe_d;
      busy_q      <= busy_d;
      rw_q        <= rw_d;
      ack_q       <= ack_d;
      wr_strobe_q <= wr_strobe_d;
      pend_q      <= pend_d;
      pend_data_q <= pend_data_d;
      regs_q      <= regs_d;
    end
  end

endmodule

// File: tb/tb_i2c_responder.sv
// Directed bench for i2c_responder: bit-banged initiator on scl/sda with a pull-up.
`timescale 1ns/1ps
module tb_i2c_responder;
  localparam int Q = 50;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic scl = 1'b1;
  logic tb_low = 1'b0;
  logic sample_valid = 1'b0;
  logic [47:0] sample = '0;
  wire sda_bus;
  logic [7:0] cfg1, cfg2;
  logic busy, wr_strobe;
  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  int dut_low_cnt = 0;

  assign sda_bus = tb_low ? 1'b0 : 1'bz;
  pullup (sda_bus);

  i2c_responder dut (
    .clock(clock), .reset(reset), .scl(scl), .sda(sda_bus),
    .sample(sample), .sample_valid(sample_valid),
    .cfg1(cfg1), .cfg2(cfg2), .busy(busy), .wr_strobe(wr_strobe)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (wr_strobe === 1'b1) wr_cnt <= wr_cnt + 1;
    if (!tb_low && sda_bus === 1'b0) dut_low_cnt <= dut_low_cnt + 1;
  end

  task automatic send_bit(input logic b);
    #(Q); tb_low = ~b; #(Q); scl = 1'b1; #(2*Q); scl = 1'b0;
  endtask

  task automatic recv_bit(output logic b);
    #(Q); tb_low = 1'b0; #(Q); scl = 1'b1; #(Q); b = sda_bus; #(Q); scl = 1'b0;
  endtask

  task automatic i2c_start();
    if (scl == 1'b0) begin
      #(Q); tb_low = 1'b0; #(Q); scl = 1'b1;
    end
    #(Q); tb_low = 1'b1; #(2*Q); scl = 1'b0;
  endtask

  task automatic i2c_stop();
    #(Q); tb_low = 1'b1; #(Q); scl = 1'b1; #(Q); tb_low = 1'b0; #(2*Q);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic a;
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    recv_bit(a);
    ack = ~a;
  endtask

  task automatic read_byte(input logic ack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(b);
      d[i] = b;
    end
    send_bit(~ack);
  endtask

  task automatic set_ptr_read(input logic [7:0] ptr, output logic ok);
    logic a0, a1, a2;
    i2c_start(); write_byte(8'h88, a0); write_byte(ptr, a1);
    i2c_start(); write_byte(8'h89, a2);
    ok = a0 & a1 & a2;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (4) @(posedge clock);
    @(negedge clock);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (wr_strobe !== 1'b0) begin errors++; $display("FAIL reset_wr_strobe got %b want 0", wr_strobe); end
    checks++; if (cfg1 !== 8'h00) begin errors++; $display("FAIL reset_cfg1 got %h want 00", cfg1); end
    checks++; if (cfg2 !== 8'h00) begin errors++; $display("FAIL reset_cfg2 got %h want 00", cfg2); end
    checks++; if (sda_bus !== 1'b1) begin errors++; $display("FAIL reset_sda got %b want 1", sda_bus); end
    reset = 1'b0;
    repeat (4) @(negedge clock);
  endtask

  task automatic test_write();
    logic a0, a1, a2, a3;
    int w0;
    w0 = wr_cnt;
    i2c_start();
    #(Q);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL write_busy_start got %b want 1", busy); end
    write_byte(8'h88, a0); write_byte(8'h01, a1); write_byte(8'h0D, a2); write_byte(8'h3F, a3);
    checks++;
    if ({a0, a1, a2, a3} !== 4'b1111) begin
      errors++; $display("FAIL write_acks got %b want 1111", {a0, a1, a2, a3});
    end
    i2c_stop();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL write_busy_stop got %b want 0", busy); end
    checks++; if (cfg1 !== 8'h0D) begin errors++; $display("FAIL write_cfg1 got %h want 0d", cfg1); end
    checks++; if (cfg2 !== 8'h3F) begin errors++; $display("FAIL write_cfg2 got %h want 3f", cfg2); end
    checks++;
    if (wr_cnt - w0 !== 2) begin errors++; $display("FAIL write_strobes got %0d want 2", wr_cnt - w0); end
  endtask

  task automatic test_sample_read();
    logic ok;
    logic [7:0] d;
    @(negedge clock); sample = 48'h0E0D0C0B0A09; sample_valid = 1'b1;
    @(negedge clock); sample_valid = 1'b0;
    set_ptr_read(8'h09, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL sread_acks got %b want 1", ok); end
    for (int i = 0; i < 6; i++) begin
      read_byte(i < 5, d);
      checks++;
      if (d !== 8'(9 + i)) begin errors++; $display("FAIL sread_byte%0d got %h want %h", i, d, 8'(9 + i)); end
    end
    i2c_stop();
  endtask

  task automatic test_bad_addr();
    logic a;
    int low0;
    low0 = dut_low_cnt;
    i2c_start();
    write_byte(8'h90, a);
    checks++; if (a !== 1'b0) begin errors++; $display("FAIL badaddr_nack got ack %b want 0", a); end
    repeat (3) @(negedge clock);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL badaddr_busy got %b want 0", busy); end
    i2c_stop();
    checks++;
    if (dut_low_cnt - low0 !== 0) begin
      errors++; $display("FAIL badaddr_sda_driven got %0d cycles want 0", dut_low_cnt - low0);
    end
    checks++; if (cfg1 !== 8'h0D) begin errors++; $display("FAIL badaddr_cfg1 got %h want 0d", cfg1); end
    checks++; if (cfg2 !== 8'h3F) begin errors++; $display("FAIL badaddr_cfg2 got %h want 3f", cfg2); end
  endtask

  task automatic test_wrap_readonly();
    logic a0, a1, a2, a3, ok;
    logic [7:0] d0, d1;
    int w0;
    w0 = wr_cnt;
    i2c_start(); write_byte(8'h88, a0); write_byte(8'h0F, a1); write_byte(8'hA5, a2); write_byte(8'h5A, a3);
    i2c_stop();
    checks++;
    if ({a0, a1, a2, a3} !== 4'b1111 || wr_cnt - w0 !== 2) begin
      errors++; $display("FAIL wrap_write got acks %b strobes %0d want 1111/2", {a0, a1, a2, a3}, wr_cnt - w0);
    end
    set_ptr_read(8'h0F, ok);
    read_byte(1'b1, d0); read_byte(1'b0, d1);
    i2c_stop();
    checks++; if (d0 !== 8'hA5) begin errors++; $display("FAIL wrap_reg0f got %h want a5", d0); end
    checks++; if (d1 !== 8'h5A) begin errors++; $display("FAIL wrap_reg00 got %h want 5a", d1); end
    w0 = wr_cnt;
    i2c_start(); write_byte(8'h88, a0); write_byte(8'h0B, a1); write_byte(8'h77, a2);
    i2c_stop();
    checks++; if (a2 !== 1'b1) begin errors++; $display("FAIL ro_ack got %b want 1", a2); end
    checks++; if (wr_cnt - w0 !== 0) begin errors++; $display("FAIL ro_strobe got %0d want 0", wr_cnt - w0); end
    set_ptr_read(8'h0B, ok);
    read_byte(1'b0, d0);
    i2c_stop();
    checks++; if (d0 !== 8'h0B) begin errors++; $display("FAIL ro_value got %h want 0b", d0); end
  endtask

  task automatic test_sample_during_read();
    logic ok;
    logic [7:0] d [6];
    set_ptr_read(8'h09, ok);
    read_byte(1'b1, d[0]);
    @(negedge clock); sample = 48'h262524232221; sample_valid = 1'b1;
    @(negedge clock); sample_valid = 1'b0;
    for (int i = 1; i < 6; i++) read_byte(i < 5, d[i]);
    i2c_stop();
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (d[i] !== 8'(9 + i)) begin errors++; $display("FAIL atomic_old%0d got %h want %h", i, d[i], 8'(9 + i)); end
    end
    set_ptr_read(8'h09, ok);
    for (int i = 0; i < 6; i++) read_byte(i < 5, d[i]);
    i2c_stop();
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (d[i] !== 8'(8'h21 + i)) begin
        errors++; $display("FAIL atomic_new%0d got %h want %h", i, d[i], 8'(8'h21 + i));
      end
    end
  endtask

  task automatic test_reset_mid_read();
    logic ok, a;
    logic [7:0] d;
    set_ptr_read(8'h09, ok);
    #(Q);
    checks++; if (sda_bus !== 1'b0) begin errors++; $display("FAIL midrst_drive got %b want 0", sda_bus); end
    @(negedge clock); reset = 1'b1;
    @(negedge clock);
    checks++; if (sda_bus !== 1'b1) begin errors++; $display("FAIL midrst_release got %b want 1", sda_bus); end
    reset = 1'b0;
    @(negedge clock);
    checks++; if (cfg1 !== 8'h00) begin errors++; $display("FAIL midrst_cfg1 got %h want 00", cfg1); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", busy); end
    i2c_start(); write_byte(8'h88, a);
    checks++; if (a !== 1'b1) begin errors++; $display("FAIL midrst_addr_ack got %b want 1", a); end
    write_byte(8'h09, a); i2c_start(); write_byte(8'h89, a);
    read_byte(1'b0, d);
    i2c_stop();
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL midrst_reg09 got %h want 00", d); end
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_write();
    test_sample_read();
    test_bad_addr();
    test_wrap_readonly();
    test_sample_during_read();
    test_reset_mid_read();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_responder.md
I2C_RESPONDER -- requirements
Module: i2c_responder

Interface
REQ-001 SHALL have parameter DEVICE_ADDRESS, default 7'h44, 7-bit target address answered on the bus.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, number of synchronizer flops on scl/sda inputs (minimum 2).
REQ-003 SHALL have port clock  input  1  system clock; all logic on posedge; frequency at least 10x SCL rate.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port scl  input  1  bus clock from initiator; never driven by this block.
REQ-006 SHALL have port sda  inout  1  bus data; driven only 1'b0 or 1'bz, never 1'b1.
REQ-007 SHALL have port sample  input  48  sensor data image; sample[8k+7:8k] maps to register 0x09+k, k=0..5.
REQ-008 SHALL have port sample_valid  input  1  one-cycle strobe to load sample into registers 0x09-0x0E.
REQ-009 SHALL have port cfg1  output  8  current content of register 0x01.
REQ-010 SHALL have port cfg2  output  8  current content of register 0x02.
REQ-011 SHALL have port busy  output  1  high from START detect until STOP detect or address NACK.
REQ-012 SHALL have port wr_strobe  output  1  one-cycle pulse per data byte written into the register file.

Function
REQ-013 SHALL synchronize scl and sda through SYNC_STAGES flops; START = sda fall while scl high; STOP = sda rise while scl high.
REQ-014 SHALL hold a 16x8 register file addressed by a 4-bit pointer; pointer wraps 0x0F->0x00.
REQ-015 SHALL use states IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT_STOP.
REQ-016 SHALL sample sda on each synchronized scl rising edge, MSB first, 8 bits per byte.
REQ-017 SHALL change its sda drive only on a synchronized scl falling edge (low-phase changes only).
REQ-018 ADDR: after 8 bits, match bits[7:1] to DEVICE_ADDRESS -> ADDR_ACK (drive 0 for the 9th clock); mismatch -> WAIT_STOP, sda released, busy low.
REQ-019 R/W bit 0 -> REG; after 8 bits, load pointer with byte[3:0] (upper nibble ignored), ACK, -> WDATA.
REQ-020 WDATA: each byte ACKed; written to reg[pointer] unless pointer in 0x09-0x0E (read-only, still ACKed, no write, no wr_strobe); pointer increments after every byte.
REQ-021 R/W bit 1 -> RDATA: shift out reg[pointer], MSB first, starting on the falling edge after the address ACK clock; release sda for the 9th clock.
REQ-022 RDATA_ACK: initiator ACK (sda 0) -> pointer+1, next byte; NACK (sda 1) -> WAIT_STOP, sda released.
REQ-023 START in any state (repeated START) SHALL release sda and enter ADDR with bit counter cleared; pointer retained.
REQ-024 STOP in any state SHALL release sda and enter IDLE; pointer retained.
REQ-025 sample_valid in IDLE or WAIT_STOP SHALL load regs 0x09-0x0E on the next cycle; otherwise held pending and applied on the first cycle back in IDLE/WAIT_STOP; a newer strobe overwrites the pending image.
REQ-026 A read in progress SHALL never observe a partially updated sample image.
REQ-027 wr_strobe SHALL pulse in the cycle after the 8th bit of a written byte is sampled; cfg1/cfg2 update in that same cycle.

Reset
REQ-028 On reset: state IDLE, sda released (z), all registers 8'h00, pointer 0, pending sample cleared, busy 0, wr_strobe 0, cfg1 = cfg2 = 8'h00.
REQ-029 Reset asserted mid-transfer SHALL release sda in the next cycle and ignore the bus until a new START.

Verification
REQ-030 Write S,0x88,0x01,0x0D,0x3F,P -> three ACKs plus address ACK; cfg1=0x0D, cfg2=0x3F; two wr_strobe pulses.
REQ-031 sample=48'h0E0D0C0B0A09 strobe, then S,0x88,0x09,Sr,0x89, read 6 bytes (ACK x5, NACK), P -> bytes 0x09,0x0A,0x0B,0x0C,0x0D,0x0E.
REQ-032 S,0x90 (address 0x48),P -> sda never driven low, busy drops after the 9th clock, registers unchanged.
REQ-033 Pointer 0x0F, read 2 bytes -> reg 0x0F then reg 0x00 (wrap); write to 0x0B -> ACKed, value unchanged, no wr_strobe.
REQ-034 sample_valid during a 6-byte read -> all 6 bytes from the old image; new image readable after P.
REQ-035 reset asserted during RDATA with sda driven 0 -> sda z next cycle; regs 0x00; next S,0x88 ACKed normally.
